// File: rtl/rr_mux_2n_to_1_if.sv
// Stream bundle for the round-robin gatherer: N valid/ready input channels plus one
// tagged output stream. The mux uses the slave view; whoever feeds and drains it uses master.
interface rr_mux_2n_to_1_if #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int LOGN = $clog2(N)
);
  logic [N*W-1:0]  inData;
  logic [N-1:0]    inValid;
  logic [N-1:0]    inReady;
  logic [W-1:0]    outData;
  logic [LOGN-1:0] outSel;
  logic            outValid;
  logic            outReady;

  modport slave (
    input  inData, inValid, outReady,
    output inReady, outData, outSel, outValid
  );

  modport master (
    output inData, inValid, outReady,
    input  inReady, outData, outSel, outValid
  );
endinterface

// File: rtl/rr_mux_2n_to_1.sv
// Round-robin N-to-1 stream multiplexer with a single registered output slot.
// outSel tags each word with its source channel so responses can be routed back.
module rr_mux_2n_to_1 #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int LOGN = $clog2(N)
) (
  input logic               clk,
  input logic               reset,
  rr_mux_2n_to_1_if.slave   bus
);

  logic [W-1:0]    out_data_q,  out_data_d;
  logic [LOGN-1:0] out_sel_q,   out_sel_d;
  logic            out_valid_q, out_valid_d;
  logic [LOGN-1:0] ptr_q,       ptr_d;

  logic            load_en;
  logic            found;
  logic            accept;
  logic [LOGN-1:0] grant;
  logic [LOGN:0]   scan_idx;
  logic [N-1:0]    in_ready;

  // The slot can take a new word when it is empty or is being drained this cycle.
  assign load_en = !out_valid_q || bus.outReady;

  always_comb begin
    found    = 1'b0;
    grant    = '0;
    scan_idx = '0;
    for (int k = 0; k < N; k++) begin
      scan_idx = {1'b0, ptr_q} + (LOGN+1)'(k);
      if (scan_idx >= (LOGN+1)'(N)) begin
        scan_idx = scan_idx - (LOGN+1)'(N);
      end
      if (!found && bus.inValid[scan_idx[LOGN-1:0]]) begin
        found = 1'b1;
        grant = scan_idx[LOGN-1:0];
      end
    end
  end

  assign accept = found && load_en && !reset;

  always_comb begin
    in_ready = '0;
    if (accept) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Wrap is explicit so non-power-of-two N never points past the last channel.
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_data_d  = bus.inData[int'(grant)*W +: W];
      out_sel_d   = grant;
      out_valid_d = 1'b1;
      ptr_d       = (grant == LOGN'(N-1)) ? '0 : grant + 1'b1;
    end else if (bus.outReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.inReady  = in_ready;
  assign bus.outData  = out_data_q;
  assign bus.outSel   = out_sel_q;
  assign bus.outValid = out_valid_q;

endmodule

// File: tb/tb_rr_mux_2n_to_1.sv
// Directed bench for rr_mux_2n_to_1: a 4-channel instance for the main scenarios
// and a 3-channel instance for the non-power-of-two pointer wrap.
module tb_rr_mux_2n_to_1;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  rr_mux_2n_to_1_if #(.N(4), .W(8)) bus4 ();
  rr_mux_2n_to_1_if #(.N(3), .W(8)) bus3 ();

  rr_mux_2n_to_1 #(.N(4), .W(8)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));
  rr_mux_2n_to_1 #(.N(3), .W(8)) dut3 (.clk(clk), .reset(reset), .bus(bus3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge, well away from the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] valid,
                               input logic [31:0] data, input logic out_ready);
    reset         = rst;
    bus4.inValid  = valid;
    bus4.inData   = data;
    bus4.outReady = out_ready;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  logic [7:0] rr_data [6];
  logic [1:0] rr_sel  [6];

  initial begin
    errors = 0;
    checks = 0;
    bus3.inValid  = '0;
    bus3.inData   = '0;
    bus3.outReady = 1'b1;
    rr_sel  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rr_data = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 8'hA0, 8'hB1};

    // Reset with every channel requesting: nothing may be accepted.
    applyStimulus(1'b1, 4'b1111, 32'h44332211, 1'b0);
    checkOutput("reset_inReady", 32'(bus4.inReady), 32'h0);
    tick();
    checkOutput("reset_inReady_hold", 32'(bus4.inReady), 32'h0);
    checkOutput("reset_outValid", 32'(bus4.outValid), 32'h0);
    checkOutput("reset_outData", 32'(bus4.outData), 32'h0);
    checkOutput("reset_outSel", 32'(bus4.outSel), 32'h0);

    // Single request on channel 2.
    applyStimulus(1'b0, 4'b0100, 32'h44A52211, 1'b1);
    checkOutput("single_inReady", 32'(bus4.inReady), 32'h4);
    tick();
    checkOutput("single_outData", 32'(bus4.outData), 32'hA5);
    checkOutput("single_outSel", 32'(bus4.outSel), 32'h2);
    checkOutput("single_outValid", 32'(bus4.outValid), 32'h1);

    // Restart the pointer, then all channels requesting continuously.
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'b1111, 32'hD3C2B1A0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("rr_sel_%0d", i), 32'(bus4.outSel), 32'(rr_sel[i]));
      checkOutput($sformatf("rr_data_%0d", i), 32'(bus4.outData), 32'(rr_data[i]));
      checkOutput($sformatf("rr_valid_%0d", i), 32'(bus4.outValid), 32'h1);
    end

    // Backpressure: fill with 8'h11 from channel 0, then stall with channel 2 pending.
    applyStimulus(1'b1, 4'b0000, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 4'b0001, 32'h00000011, 1'b1);
    tick();
    checkOutput("bp_fill_data", 32'(bus4.outData), 32'h11);
    applyStimulus(1'b0, 4'b0100, 32'h00220011, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("bp_inReady_%0d", i), 32'(bus4.inReady), 32'h0);
      tick();
      checkOutput($sformatf("bp_outData_%0d", i), 32'(bus4.outData), 32'h11);
      checkOutput($sformatf("bp_outSel_%0d", i), 32'(bus4.outSel), 32'h0);
      checkOutput($sformatf("bp_outValid_%0d", i), 32'(bus4.outValid), 32'h1);
    end
    applyStimulus(1'b0, 4'b0100, 32'h00220011, 1'b1);
    checkOutput("bp_release_inReady", 32'(bus4.inReady), 32'h4);
    tick();
    checkOutput("bp_release_outData", 32'(bus4.outData), 32'h22);
    checkOutput("bp_release_outSel", 32'(bus4.outSel), 32'h2);
    checkOutput("bp_release_outValid", 32'(bus4.outValid), 32'h1);

    // Drain with nothing offered: slot empties, data and tag keep their values.
    applyStimulus(1'b0, 4'b0000, 32'h0, 1'b1);
    tick();
    checkOutput("drain_outValid", 32'(bus4.outValid), 32'h0);
    checkOutput("drain_outData", 32'(bus4.outData), 32'h22);
    checkOutput("drain_outSel", 32'(bus4.outSel), 32'h2);

    // Reset mid-stream with a held word 8'h7E.
    applyStimulus(1'b0, 4'b0010, 32'h00007E00, 1'b0);
    tick();
    checkOutput("mid_fill_data", 32'(bus4.outData), 32'h7E);
    applyStimulus(1'b1, 4'b1000, 32'h99000000, 1'b0);
    checkOutput("mid_reset_inReady", 32'(bus4.inReady), 32'h0);
    tick();
    checkOutput("mid_reset_outValid", 32'(bus4.outValid), 32'h0);
    checkOutput("mid_reset_outData", 32'(bus4.outData), 32'h0);
    checkOutput("mid_reset_outSel", 32'(bus4.outSel), 32'h0);
    // Pointer was 2 before reset; a restarted pointer prefers channel 1 over 3.
    applyStimulus(1'b0, 4'b1010, 32'h99008800, 1'b1);
    checkOutput("mid_ptr_restart", 32'(bus4.inReady), 32'h2);
    applyStimulus(1'b0, 4'b1000, 32'h99000000, 1'b1);
    checkOutput("mid_ch3_inReady", 32'(bus4.inReady), 32'h8);
    tick();
    checkOutput("mid_ch3_outSel", 32'(bus4.outSel), 32'h3);
    checkOutput("mid_ch3_outData", 32'(bus4.outData), 32'h99);
    applyStimulus(1'b0, 4'b0000, 32'h0, 1'b1);

    // Three channels: grant 2 must wrap the pointer to 0, then grant 0 moves it to 1.
    bus3.inValid = 3'b100;
    bus3.inData  = 24'hC2B1A0;
    #1;
    checkOutput("n3_grant2_inReady", 32'(bus3.inReady), 32'h4);
    tick();
    checkOutput("n3_grant2_outSel", 32'(bus3.outSel), 32'h2);
    checkOutput("n3_grant2_outData", 32'(bus3.outData), 32'hC2);
    bus3.inValid = 3'b011;
    #1;
    checkOutput("n3_wrap_inReady", 32'(bus3.inReady), 32'h1);
    bus3.inValid = 3'b001;
    #1;
    tick();
    checkOutput("n3_grant0_outSel", 32'(bus3.outSel), 32'h0);
    checkOutput("n3_grant0_outData", 32'(bus3.outData), 32'hA0);
    bus3.inValid = 3'b111;
    #1;
    checkOutput("n3_ptr1_inReady", 32'(bus3.inReady), 32'h2);
    tick();
    checkOutput("n3_ptr1_outSel", 32'(bus3.outSel), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
